// File: rtl/wdt_reset_escalator.sv
// wdt_reset_escalator: watchdog timeout escalation.
// A timeout raises a warning interrupt and runs a programmable grace count.
// Without a valid acknowledge, a fixed-length reset pulse is issued, after
// which the block holds off until the timeout level clears.
// Optional build macro: WDT_ESC_LOCK_EN adds a sticky CTRL/GRACE write lock.
module wdt_reset_escalator #(
    parameter int unsigned PULSE_LEN = 16,
    parameter int unsigned GRACE_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timeout_in,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        warn_irq,
    output logic        reset_out
);

    localparam int unsigned PCNT_W = $clog2(PULSE_LEN + 1);

    localparam logic [5:0] ADDR_CTRL   = 6'h00;
    localparam logic [5:0] ADDR_GRACE  = 6'h04;
    localparam logic [5:0] ADDR_ACK    = 6'h08;
    localparam logic [5:0] ADDR_STATUS = 6'h0C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WARN = 2'd1,
        ST_FIRE = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic                 enable_q;
    logic [GRACE_W-1:0]   grace_q;
    logic [GRACE_W-1:0]   grace_cnt_q;
    logic [PCNT_W-1:0]    pulse_cnt_q;
    logic [7:0]           fire_cnt_q;
    logic                 warn_d, reset_d;
    logic                 locked;

    logic                 wr_en_c, rd_en_c, ack_c, ctrl_wr_c, grace_wr_c;
    logic [31:0]          wr_data_c, rd_data_c;

    // Write data zero-extended according to the access width.
    always_comb begin
        wr_data_c = data_in;
        case (data_write_n)
            2'b00:   wr_data_c = {24'd0, data_in[7:0]};
            2'b01:   wr_data_c = {16'd0, data_in[15:0]};
            default: wr_data_c = data_in;
        endcase
    end

    assign wr_en_c    = (data_write_n != 2'b11);
    assign rd_en_c    = (data_read_n != 2'b11);
    assign ack_c      = wr_en_c && (address == ADDR_ACK) && (data_in[7:0] == 8'hA5);
    assign ctrl_wr_c  = wr_en_c && (address == ADDR_CTRL) && !locked;
    assign grace_wr_c = wr_en_c && (address == ADDR_GRACE) && !locked;

`ifdef WDT_ESC_LOCK_EN
    logic lock_q;

    // Sticky lock: set by CTRL bit1, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= 1'b0;
        end else if (ctrl_wr_c && wr_data_c[1]) begin
            lock_q <= 1'b1;
        end
    end

    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    // Software-visible configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q <= 1'b0;
            grace_q  <= '0;
        end else begin
            if (ctrl_wr_c) begin
                enable_q <= wr_data_c[0];
            end
            if (grace_wr_c) begin
                grace_q <= GRACE_W'(wr_data_c);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; ACK/deassert/disable take priority over expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable_q && timeout_in) begin
                    state_d = (grace_q == '0) ? ST_FIRE : ST_WARN;
                end
            end
            ST_WARN: begin
                if (ack_c || !timeout_in || !enable_q) begin
                    state_d = ST_IDLE;
                end else if (grace_cnt_q == GRACE_W'(1)) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                if (pulse_cnt_q == PCNT_W'(1)) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!timeout_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output decode, evaluated on the next state so the registers line up.
    always_comb begin
        warn_d  = 1'b0;
        reset_d = 1'b0;
        case (state_d)
            ST_WARN: warn_d  = 1'b1;
            ST_FIRE: reset_d = 1'b1;
            default: ;
        endcase
    end

    // Registered interrupt and reset outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            warn_irq  <= 1'b0;
            reset_out <= 1'b0;
        end else begin
            warn_irq  <= warn_d;
            reset_out <= reset_d;
        end
    end

    // Grace and pulse counters, plus the saturating fire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            grace_cnt_q <= '0;
            pulse_cnt_q <= '0;
            fire_cnt_q  <= '0;
        end else begin
            if (state_q == ST_IDLE && state_d == ST_WARN) begin
                grace_cnt_q <= grace_q;
            end else if (state_q == ST_WARN) begin
                grace_cnt_q <= grace_cnt_q - GRACE_W'(1);
            end

            if (state_q != ST_FIRE && state_d == ST_FIRE) begin
                pulse_cnt_q <= PCNT_W'(PULSE_LEN);
                if (fire_cnt_q != 8'hFF) begin
                    fire_cnt_q <= fire_cnt_q + 8'd1;
                end
            end else if (state_q == ST_FIRE) begin
                pulse_cnt_q <= pulse_cnt_q - PCNT_W'(1);
            end
        end
    end

    // Read data mux; unmapped and write-only addresses read as zero.
    always_comb begin
        rd_data_c = 32'd0;
        case (address)
            ADDR_CTRL:   rd_data_c = {30'd0, locked, enable_q};
            ADDR_GRACE:  rd_data_c = 32'(grace_q);
            ADDR_STATUS: rd_data_c = {22'd0, fire_cnt_q, state_q};
            default:     rd_data_c = 32'd0;
        endcase
    end

    // Read response, one cycle after the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_ready <= 1'b0;
            data_out   <= 32'd0;
        end else begin
            data_ready <= rd_en_c;
            data_out   <= rd_en_c ? rd_data_c : 32'd0;
        end
    end

endmodule

// File: tb/tb_wdt_reset_escalator.sv
// Testbench for wdt_reset_escalator: scoreboard of expected read data plus
// per-scenario timing checks of warn_irq / reset_out.
module tb_wdt_reset_escalator;

    logic        clk = 1'b0;
    logic        rst;
    logic        timeout_in;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        warn_irq;
    logic        reset_out;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    wdt_reset_escalator dut (
        .clk          (clk),
        .rst          (rst),
        .timeout_in   (timeout_in),
        .address      (address),
        .data_in      (data_in),
        .data_write_n (data_write_n),
        .data_read_n  (data_read_n),
        .data_out     (data_out),
        .data_ready   (data_ready),
        .warn_irq     (warn_irq),
        .reset_out    (reset_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w);
        address      = a;
        data_in      = d;
        data_write_n = w;
        tick();
        data_write_n = 2'b11;
    endtask

    // Push expectation, issue a one-cycle read, pop and compare on data_ready.
    task automatic bus_read(input logic [5:0] a, input logic [31:0] e, input string nm);
        logic [31:0] exp_v;
        exp_q.push_back(e);
        address     = a;
        data_read_n = 2'b10;
        tick();
        data_read_n = 2'b11;
        total++;
        if (data_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready: got %b want 1", nm, data_ready);
        end
        exp_v = exp_q.pop_front();
        total++;
        if (data_out !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, data_out, exp_v);
        end
        tick();
        total++;
        if (data_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s_ready_drop: got %b want 0", nm, data_ready);
        end
    endtask

    task automatic count_resets(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            if (reset_out) n++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; timeout_in = 1'b0; address = '0; data_in = '0;
        data_write_n = 2'b11; data_read_n = 2'b11;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        total++;
        if ({warn_irq, reset_out, data_ready, data_out} !== 35'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b%b%b %h want 0", warn_irq, reset_out, data_ready, data_out);
        end
        bus_read(6'h00, 32'd0, "rst_ctrl");
        bus_read(6'h04, 32'd0, "rst_grace");
        bus_read(6'h0C, 32'd0, "rst_status");
    endtask

    task automatic test_fire();
        int n;
        bus_write(6'h04, 32'd10, 2'b10);
        bus_write(6'h00, 32'd1, 2'b10);
        timeout_in = 1'b1;
        tick();
        total++;
        if (warn_irq !== 1'b1 || reset_out !== 1'b0) begin
            bad++;
            $display("FAIL fire_warn_rise: got w%b r%b want w1 r0", warn_irq, reset_out);
        end
        repeat (9) tick();
        total++;
        if (warn_irq !== 1'b1 || reset_out !== 1'b0) begin
            bad++;
            $display("FAIL fire_before_expiry: got w%b r%b want w1 r0", warn_irq, reset_out);
        end
        tick();
        total++;
        if (warn_irq !== 1'b0 || reset_out !== 1'b1) begin
            bad++;
            $display("FAIL fire_rise_at_10: got w%b r%b want w0 r1", warn_irq, reset_out);
        end
        n = 0;
        for (int k = 0; k < 40 && reset_out; k++) begin
            n++;
            tick();
        end
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL fire_pulse_len: got %0d want 16", n);
        end
        bus_read(6'h0C, 32'h7, "fire_status_hold");
        timeout_in = 1'b0;
        tick();
        bus_read(6'h0C, 32'h4, "fire_status_idle");
    endtask

    task automatic test_ack();
        int n;
        timeout_in = 1'b1;
        tick();
        repeat (4) tick();
        bus_write(6'h08, 32'h0000_00A5, 2'b00);
        total++;
        if (warn_irq !== 1'b0) begin
            bad++;
            $display("FAIL ack_good_warn: got %b want 0", warn_irq);
        end
        timeout_in = 1'b0;
        count_resets(20, n);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL ack_good_nofire: got %0d want 0", n);
        end
        timeout_in = 1'b1;
        tick();
        repeat (4) tick();
        bus_write(6'h08, 32'h0000_0012, 2'b00);
        total++;
        if (warn_irq !== 1'b1) begin
            bad++;
            $display("FAIL ack_bad_warn: got %b want 1", warn_irq);
        end
        n = 0;
        while (!reset_out && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n != 5) begin
            bad++;
            $display("FAIL ack_bad_fire_delay: got %0d want 5", n);
        end
        for (int k = 0; k < 40 && reset_out; k++) tick();
        timeout_in = 1'b0;
        tick();
        bus_read(6'h0C, 32'h8, "ack_bad_status");
    endtask

    task automatic test_precedence();
        int n;
        bus_write(6'h04, 32'd3, 2'b10);
        timeout_in = 1'b1;
        tick();
        repeat (2) tick();
        bus_write(6'h08, 32'h0000_00A5, 2'b10);
        total++;
        if (warn_irq !== 1'b0 || reset_out !== 1'b0) begin
            bad++;
            $display("FAIL ack_at_expiry: got w%b r%b want w0 r0", warn_irq, reset_out);
        end
        timeout_in = 1'b0;
        count_resets(20, n);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL ack_at_expiry_nofire: got %0d want 0", n);
        end
        timeout_in = 1'b1;
        tick();
        repeat (2) tick();
        timeout_in = 1'b0;
        tick();
        total++;
        if (warn_irq !== 1'b0 || reset_out !== 1'b0) begin
            bad++;
            $display("FAIL drop_mid_warn: got w%b r%b want w0 r0", warn_irq, reset_out);
        end
        count_resets(20, n);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL drop_mid_warn_nofire: got %0d want 0", n);
        end
    endtask

    task automatic test_grace_zero();
        int n;
        int w;
        bus_write(6'h04, 32'd0, 2'b10);
        timeout_in = 1'b1;
        tick();
        total++;
        if (warn_irq !== 1'b0 || reset_out !== 1'b1) begin
            bad++;
            $display("FAIL gz_direct_fire: got w%b r%b want w0 r1", warn_irq, reset_out);
        end
        n = 0; w = 0;
        for (int k = 0; k < 100; k++) begin
            if (reset_out) n++;
            if (warn_irq) w++;
            tick();
        end
        total++;
        if (n != 16 || w != 0) begin
            bad++;
            $display("FAIL gz_single_pulse: got pulse %0d warn %0d want 16 0", n, w);
        end
        bus_read(6'h0C, 32'hF, "gz_status_hold");
        timeout_in = 1'b0;
        tick();
        bus_read(6'h0C, 32'hC, "gz_status_idle");
    endtask

    task automatic test_late_enable();
        int n;
        bus_write(6'h04, 32'd10, 2'b10);
        bus_write(6'h00, 32'd0, 2'b10);
        timeout_in = 1'b1;
        repeat (3) tick();
        total++;
        if (warn_irq !== 1'b0) begin
            bad++;
            $display("FAIL disabled_no_warn: got %b want 0", warn_irq);
        end
        bus_write(6'h00, 32'd1, 2'b10);
        tick();
        total++;
        if (warn_irq !== 1'b1) begin
            bad++;
            $display("FAIL late_enable_warn: got %b want 1", warn_irq);
        end
        bus_write(6'h04, 32'd2, 2'b10);
        n = 0;
        while (!reset_out && n < 30) begin
            tick();
            n++;
        end
        total++;
        if (n != 9) begin
            bad++;
            $display("FAIL grace_write_in_warn: got %0d want 9", n);
        end
        for (int k = 0; k < 40 && reset_out; k++) tick();
        timeout_in = 1'b0;
        tick();
        bus_read(6'h04, 32'd2, "grace_applied_later");
    endtask

    task automatic test_widths();
        logic [31:0] exp_v;
        bus_write(6'h04, 32'h0012_3456, 2'b01);
        bus_read(6'h04, 32'h0000_3456, "grace_w16");
        bus_write(6'h04, 32'h0012_3456, 2'b00);
        bus_read(6'h04, 32'h0000_0056, "grace_w8");
        bus_write(6'h04, 32'h0012_3456, 2'b10);
        bus_read(6'h04, 32'h0000_3456, "grace_w32");
        bus_read(6'h20, 32'd0, "unmapped_read");
        bus_read(6'h08, 32'd0, "ack_read_zero");
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_v;
        exp_q.push_back(32'h0000_3456);
        address = 6'h04; data_read_n = 2'b01;
        tick();
        exp_v = exp_q.pop_front();
        total++;
        if (data_ready !== 1'b1 || data_out !== exp_v) begin
            bad++;
            $display("FAIL b2b_first: got %b %h want 1 %h", data_ready, data_out, exp_v);
        end
        exp_q.push_back(32'h0000_0010);
        address = 6'h0C;
        tick();
        data_read_n = 2'b11;
        exp_v = exp_q.pop_front();
        total++;
        if (data_ready !== 1'b1 || data_out !== exp_v) begin
            bad++;
            $display("FAIL b2b_second: got %b %h want 1 %h", data_ready, data_out, exp_v);
        end
        tick();
        total++;
        if (data_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready_drop: got %b want 0", data_ready);
        end
    endtask

    task automatic test_rst_in_fire();
        bus_write(6'h04, 32'd0, 2'b10);
        bus_write(6'h00, 32'd1, 2'b10);
        timeout_in = 1'b1;
        tick();
        total++;
        if (reset_out !== 1'b1) begin
            bad++;
            $display("FAIL rst_fire_setup: got %b want 1", reset_out);
        end
        rst = 1'b1;
        tick();
        total++;
        if (reset_out !== 1'b0 || warn_irq !== 1'b0) begin
            bad++;
            $display("FAIL rst_drops_pulse: got w%b r%b want w0 r0", warn_irq, reset_out);
        end
        timeout_in = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        bus_read(6'h00, 32'd0, "rst_fire_ctrl");
        bus_read(6'h0C, 32'd0, "rst_fire_status");
    endtask

    task automatic test_lock();
`ifdef WDT_ESC_LOCK_EN
        bus_write(6'h04, 32'd7, 2'b10);
        bus_write(6'h00, 32'd3, 2'b10);
        bus_read(6'h00, 32'd3, "lock_set");
        bus_write(6'h00, 32'd0, 2'b10);
        bus_write(6'h04, 32'd5, 2'b10);
        bus_read(6'h00, 32'd3, "lock_ctrl_held");
        bus_read(6'h04, 32'd7, "lock_grace_held");
`else
        bus_write(6'h00, 32'd3, 2'b10);
        bus_read(6'h00, 32'd1, "nolock_ctrl");
        bus_write(6'h04, 32'd5, 2'b10);
        bus_read(6'h04, 32'd5, "nolock_grace");
        bus_write(6'h00, 32'd0, 2'b10);
        bus_read(6'h00, 32'd0, "nolock_ctrl_clear");
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        bus_read(6'h00, 32'd0, "lock_rst_ctrl");
        bus_read(6'h04, 32'd0, "lock_rst_grace");
    endtask

    initial begin
        test_reset();
        test_fire();
        test_ack();
        test_precedence();
        test_grace_zero();
        test_late_enable();
        test_widths();
        test_back_to_back();
        test_rst_in_fire();
        test_lock();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
